// File: rtl/pong_btn_cond.sv
// rtl/pong_btn_cond.sv - push-button synchroniser, debouncer and press-pulse generator
// Optional feature macro: BTN_HOLD_REPEAT_EN (adds hold-to-repeat press pulses).
// Each channel is fully independent. Channel state is a two-flop synchroniser,
// a debounce counter, the accepted level and the press pulse.

module pong_btn_cond #(
  parameter int N_BTN         = 5,
  parameter int DB_CYCLES     = 1_000_000,
  parameter int REPEAT_CYCLES = 25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press
);

  localparam int             CW      = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

`ifdef BTN_HOLD_REPEAT_EN
  localparam int             RW      = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0]  REP_MAX = RW'(REPEAT_CYCLES - 1);
`else
  // REPEAT_CYCLES has no effect in this build; folded into a deliberately unused net.
  logic rep_cfg_unused;
  assign rep_cfg_unused = (REPEAT_CYCLES != 0);
`endif

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    // Two-flop synchroniser for the raw asynchronous button input.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_q <= 1'b0;
        s2_q <= 1'b0;
      end else begin
        s1_q <= btn_raw[i];
        s2_q <= s1_q;
      end
    end

    // Debounce: count consecutive mismatching cycles; any matching cycle restarts the count.
    always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      accept  = 1'b0;
      if (s2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        level_d = ~level_q;
        accept  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

`ifdef BTN_HOLD_REPEAT_EN
    logic [RW-1:0] rep_q, rep_d;
    logic          rep_fire;

    // Hold-repeat timer: runs only while the accepted level is high and between transitions.
    always_comb begin
      rep_d    = rep_q;
      rep_fire = 1'b0;
      if (accept || !level_q) begin
        rep_d = '0;
      end else if (rep_q == REP_MAX) begin
        rep_d    = '0;
        rep_fire = 1'b1;
      end else begin
        rep_d = rep_q + RW'(1);
      end
    end

    // Repeat counter register.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rep_q <= '0;
      end else begin
        rep_q <= rep_d;
      end
    end

    // Press pulse on an accepted rising edge or on a hold-repeat tick.
    always_comb begin
      press_d = (accept && !level_q) || rep_fire;
    end
`else
    // Press pulse only on an accepted rising edge; a release never pulses.
    always_comb begin
      press_d = accept && !level_q;
    end
`endif

    // Debounce state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        level_q <= level_d;
        press_q <= press_d;
      end
    end

    assign btn_level[i] = level_q;
    assign btn_press[i] = press_q;
  end

endmodule
